arith_arbiter_ctrl: RTL and testbench

- Two-requester round-robin arbiter and sequencer for the shared signed arithmetic/compare datapath of the synchronous arithmetic unit.
- Accepts one operation at a time through a valid/ready handshake, captures the operands, and runs the datapath for a fixed number of execute cycles.
- Returns a registered result and flag to the owning requester, holding it until that requester accepts.

---
 rtl/arith_ctrl_pkg.sv | 19 +
 rtl/arith_core.sv | 53 +++++
 rtl/arith_arbiter_ctrl.sv | 147 ++++++++++++++
 tb/tb_arith_arbiter_ctrl.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/arith_ctrl_pkg.sv
// Shared types and constants for the arithmetic arbiter/sequencer and its datapath.
package arith_ctrl_pkg;

    typedef enum logic [1:0] {
        OP_CMP_GT = 2'b00,
        OP_CMP_EQ = 2'b01,
        OP_SUB    = 2'b10,
        OP_MAX    = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        EXEC = 2'b01,
        RESP = 2'b10
    } state_e;

    localparam int CNT_W = 4;

endpackage

// File: rtl/arith_core.sv
// Combinational signed compare/subtract/max datapath shared by both requesters.
module arith_core
    import arith_ctrl_pkg::*;
#(
    parameter int BITS = 32
) (
    input  op_e               i_op,
    input  logic [BITS-1:0]   i_a,
    input  logic [BITS-1:0]   i_b,
    output logic [BITS-1:0]   o_result,
    output logic              o_flag
);

    logic            w_gt;
    logic            w_eq;
    logic [BITS-1:0] w_diff;
    logic            w_ovf;

    assign w_gt   = ($signed(i_a) > $signed(i_b));
    assign w_eq   = (i_a == i_b);
    assign w_diff = i_a - i_b;
    // Overflow only possible when operand signs differ and the result sign leaves A's.
    assign w_ovf  = (i_a[BITS-1] != i_b[BITS-1]) && (w_diff[BITS-1] != i_a[BITS-1]);

    // Operation select
    always_comb begin
        o_result = {BITS{1'b0}};
        o_flag   = 1'b0;
        case (i_op)
            OP_CMP_GT: begin
                o_result = {{(BITS-1){1'b0}}, w_gt};
                o_flag   = w_gt;
            end
            OP_CMP_EQ: begin
                o_result = {{(BITS-1){1'b0}}, w_eq};
                o_flag   = w_eq;
            end
            OP_SUB: begin
                o_result = w_diff;
                o_flag   = w_ovf;
            end
            OP_MAX: begin
                o_result = w_gt ? i_a : i_b;
                o_flag   = w_gt;
            end
            default: begin
                o_result = {BITS{1'b0}};
                o_flag   = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/arith_arbiter_ctrl.sv
// Two-requester round-robin arbiter and fixed-latency sequencer for arith_core.
module arith_arbiter_ctrl
    import arith_ctrl_pkg::*;
#(
    parameter int BITS        = 32,
    parameter int EXEC_CYCLES = 2
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic [1:0]        i_req_valid,
    output logic [1:0]        o_req_ready,
    input  logic [1:0]        i_op0,
    input  logic [1:0]        i_op1,
    input  logic [BITS-1:0]   i_arg_A0,
    input  logic [BITS-1:0]   i_arg_B0,
    input  logic [BITS-1:0]   i_arg_A1,
    input  logic [BITS-1:0]   i_arg_B1,
    output logic [1:0]        o_rsp_valid,
    input  logic [1:0]        i_rsp_ready,
    output logic [BITS-1:0]   o_result,
    output logic              o_flag,
    output logic              o_grant_id,
    output logic              o_busy
);

    state_e            r_state;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_last_grant;
    logic              r_grant_id;
    op_e               r_op;
    logic [BITS-1:0]   r_a;
    logic [BITS-1:0]   r_b;
    logic [BITS-1:0]   r_result;
    logic              r_flag;
    logic [1:0]        r_rsp_valid;

    logic              w_grant_any;
    logic              w_grant;
    logic [1:0]        w_req_ready;
    logic              w_req_fire;
    logic              w_rsp_fire;
    logic [BITS-1:0]   w_core_result;
    logic              w_core_flag;

    arith_core #(.BITS(BITS)) u_core (
        .i_op     (r_op),
        .i_a      (r_a),
        .i_b      (r_b),
        .o_result (w_core_result),
        .o_flag   (w_core_flag)
    );

    // Round-robin pick: on a tie the requester not granted last time wins
    always_comb begin
        w_grant_any = 1'b0;
        w_grant     = 1'b0;
        case (i_req_valid)
            2'b01: begin
                w_grant_any = 1'b1;
                w_grant     = 1'b0;
            end
            2'b10: begin
                w_grant_any = 1'b1;
                w_grant     = 1'b1;
            end
            2'b11: begin
                w_grant_any = 1'b1;
                w_grant     = ~r_last_grant;
            end
            default: begin
                w_grant_any = 1'b0;
                w_grant     = 1'b0;
            end
        endcase
    end

    // Ready only toward the granted requester, and only while idle
    always_comb begin
        w_req_ready = 2'b00;
        if ((r_state == IDLE) && w_grant_any) begin
            w_req_ready[w_grant] = 1'b1;
        end else begin
            w_req_ready = 2'b00;
        end
    end

    assign w_req_fire = |(i_req_valid & w_req_ready);
    assign w_rsp_fire = i_rsp_ready[r_grant_id];

    // Sequencer FSM with operand capture and registered response
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state      <= IDLE;
            r_cnt        <= {CNT_W{1'b0}};
            r_last_grant <= 1'b1;
            r_grant_id   <= 1'b0;
            r_op         <= OP_CMP_GT;
            r_a          <= {BITS{1'b0}};
            r_b          <= {BITS{1'b0}};
            r_result     <= {BITS{1'b0}};
            r_flag       <= 1'b0;
            r_rsp_valid  <= 2'b00;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_req_fire) begin
                        r_op         <= w_grant ? op_e'(i_op1) : op_e'(i_op0);
                        r_a          <= w_grant ? i_arg_A1 : i_arg_A0;
                        r_b          <= w_grant ? i_arg_B1 : i_arg_B0;
                        r_grant_id   <= w_grant;
                        r_last_grant <= w_grant;
                        r_cnt        <= CNT_W'(EXEC_CYCLES - 1);
                        r_state      <= EXEC;
                    end
                end
                EXEC: begin
                    if (r_cnt == {CNT_W{1'b0}}) begin
                        r_result    <= w_core_result;
                        r_flag      <= w_core_flag;
                        r_rsp_valid <= r_grant_id ? 2'b10 : 2'b01;
                        r_state     <= RESP;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                RESP: begin
                    if (w_rsp_fire) begin
                        r_rsp_valid <= 2'b00;
                        r_state     <= IDLE;
                    end
                end
                default: begin
                    r_rsp_valid <= 2'b00;
                    r_state     <= IDLE;
                end
            endcase
        end
    end

    assign o_req_ready = w_req_ready;
    assign o_rsp_valid = r_rsp_valid;
    assign o_result    = r_result;
    assign o_flag      = r_flag;
    assign o_grant_id  = r_grant_id;
    assign o_busy      = (r_state != IDLE);

endmodule

// File: tb/tb_arith_arbiter_ctrl.sv
// Directed self-checking bench for arith_arbiter_ctrl with hand-computed expectations.
module tb_arith_arbiter_ctrl;

    localparam int BITS = 32;
    localparam int EXEC = 2;

    logic            clk;
    logic            rst_n;
    logic [1:0]      req_valid;
    logic [1:0]      req_ready;
    logic [1:0]      op0, op1;
    logic [BITS-1:0] a0, b0, a1, b1;
    logic [1:0]      rsp_valid;
    logic [1:0]      rsp_ready;
    logic [BITS-1:0] result;
    logic            flag;
    logic            grant_id;
    logic            busy;

    int checks = 0;
    int errors = 0;

    arith_arbiter_ctrl #(.BITS(BITS), .EXEC_CYCLES(EXEC)) dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_req_valid (req_valid),
        .o_req_ready (req_ready),
        .i_op0       (op0),
        .i_op1       (op1),
        .i_arg_A0    (a0),
        .i_arg_B0    (b0),
        .i_arg_A1    (a1),
        .i_arg_B1    (b1),
        .o_rsp_valid (rsp_valid),
        .i_rsp_ready (rsp_ready),
        .o_result    (result),
        .o_flag      (flag),
        .o_grant_id  (grant_id),
        .o_busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One complete transaction from requester r with immediate response accept.
    task automatic run_op(input string tag, input int r, input logic [1:0] op,
                          input logic [BITS-1:0] a, input logic [BITS-1:0] b,
                          input logic [BITS-1:0] exp_res, input logic exp_flag);
        logic [1:0] own;
        own = (r == 1) ? 2'b10 : 2'b01;
        if (r == 1) begin op1 = op; a1 = a; b1 = b; end
        else        begin op0 = op; a0 = a; b0 = b; end
        req_valid = own;
        rsp_ready = 2'b00;
        #1;
        chk({tag, "_ready"}, 64'(req_ready), 64'(own));
        tick();
        req_valid = 2'b00;
        chk({tag, "_busy"}, 64'(busy), 64'd1);
        chk({tag, "_gid"}, 64'(grant_id), 64'(r));
        for (int i = 0; i < EXEC - 1; i++) begin
            tick();
            chk({tag, "_early"}, 64'(rsp_valid), 64'd0);
        end
        tick();
        chk({tag, "_rspv"}, 64'(rsp_valid), 64'(own));
        chk({tag, "_res"}, 64'(result), 64'(exp_res));
        chk({tag, "_flag"}, 64'(flag), 64'(exp_flag));
        rsp_ready = own;
        tick();
        rsp_ready = 2'b00;
        chk({tag, "_done"}, 64'({busy, rsp_valid}), 64'd0);
    endtask

    initial begin
        rst_n = 1'b0; req_valid = 2'b00; rsp_ready = 2'b00;
        op0 = 2'b00; op1 = 2'b00; a0 = '0; b0 = '0; a1 = '0; b1 = '0;
        #12;
        chk("rst_outs", {result, flag, grant_id, rsp_valid, busy}, 64'd0);
        chk("rst_ready", 64'(req_ready), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // Same-cycle ready in IDLE, then CMP_GT vectors
        run_op("gt_neg", 0, 2'b00, -32'sd5, 32'sd3, 32'd0, 1'b0);
        run_op("gt_pos", 0, 2'b00, 32'sd7, -32'sd2, 32'd1, 1'b1);
        run_op("gt_min", 0, 2'b00, 32'h8000_0000, 32'd0, 32'd0, 1'b0);

        // SUB on requester 1
        run_op("sub_ovf", 1, 2'b10, 32'h7FFF_FFFF, 32'hFFFF_FFFF, 32'h8000_0000, 1'b1);
        run_op("sub_ok", 1, 2'b10, 32'd10, 32'd3, 32'd7, 1'b0);

        // Round robin from a fresh reset, both valid, immediate accept
        rst_n = 1'b0; #1; rst_n = 1'b1;
        op0 = 2'b01; a0 = 32'd5; b0 = 32'd5;
        op1 = 2'b10; a1 = 32'd100; b1 = 32'd1;
        req_valid = 2'b11;
        rsp_ready = 2'b11;
        for (int k = 0; k < 4; k++) begin
            #1;
            chk("rr_ready", 64'(req_ready), (k % 2 == 0) ? 64'd1 : 64'd2);
            tick();
            chk("rr_gid", 64'(grant_id), 64'(k % 2));
            chk("rr_exec_ready", 64'(req_ready), 64'd0);
            for (int i = 0; i < EXEC; i++) tick();
            chk("rr_rspv", 64'(rsp_valid), (k % 2 == 0) ? 64'd1 : 64'd2);
            chk("rr_res", 64'(result), (k % 2 == 0) ? 64'd1 : 64'd99);
            chk("rr_resp_ready", 64'(req_ready), 64'd0);
            tick();
        end
        req_valid = 2'b00;
        rsp_ready = 2'b00;
        tick();
        chk("rr_idle", 64'(busy), 64'd0);

        // Backpressure on MAX; requester 1 waits and non-owner accept is ignored
        op0 = 2'b11; a0 = 32'hFFFF_FFFF; b0 = 32'hFFFF_FFF7;
        req_valid = 2'b01;
        #1;
        tick();
        req_valid = 2'b10;
        op1 = 2'b00; a1 = 32'd1; b1 = 32'd0;
        for (int i = 0; i < EXEC; i++) tick();
        rsp_ready = 2'b10;
        for (int i = 0; i < 5; i++) begin
            chk("bp_res", 64'(result), 64'hFFFF_FFFF);
            chk("bp_flag", 64'(flag), 64'd1);
            chk("bp_ready", 64'(req_ready), 64'd0);
            chk("bp_busy", 64'(busy), 64'd1);
            chk("bp_rspv", 64'(rsp_valid), 64'd1);
            tick();
        end
        rsp_ready = 2'b01;
        tick();
        rsp_ready = 2'b00;
        chk("bp_release_ready", 64'(req_ready), 64'd2);
        // Valid withdrawn before the edge: nothing is captured
        req_valid = 2'b00;
        tick();
        chk("withdraw_idle", 64'(busy), 64'd0);

        // Reset in the first EXEC cycle drops the operation
        op0 = 2'b10; a0 = 32'd10; b0 = 32'd3;
        req_valid = 2'b01;
        #1;
        tick();
        req_valid = 2'b00;
        chk("pre_rst_busy", 64'(busy), 64'd1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_outs", {result, flag, grant_id, rsp_valid, busy}, 64'd0);
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < EXEC + 3; i++) begin
            tick();
            chk("no_rsp", 64'({busy, rsp_valid}), 64'd0);
        end
        run_op("eq_zero", 0, 2'b01, 32'd0, 32'd0, 32'd1, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
